// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the data-memory bus master.
package mem_bus_ctrl_pkg;

    localparam int REG_DATA_WIDTH          = 32;
    localparam int BYTE_SLCT_WIDTH         = 4;
    localparam int MEM_BUS_TIMEOUT_DEFAULT = 16;
    localparam int TMO_CNT_WIDTH           = 8;

    // Bus FSM encodings; exposed on the debug port of the top.
    typedef enum logic [1:0] {
        MBC_IDLE = 2'd0,
        MBC_REQ  = 2'd1,
        MBC_DONE = 2'd2
    } mbc_state_e;

    // Word-align a byte address by clearing the two lane-select bits.
    function automatic logic [REG_DATA_WIDTH-1:0] word_align(
        input logic [REG_DATA_WIDTH-1:0] byte_addr
    );
        return byte_addr & ~REG_DATA_WIDTH'(3);
    endfunction

endpackage

// File: rtl/mbc_timeout_cnt.sv
// Cycle counter for the request phase; flags when the configured limit is reached.
module mbc_timeout_cnt
    import mem_bus_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic [TMO_CNT_WIDTH-1:0] limit,
    output logic                     expire
);

    logic [TMO_CNT_WIDTH-1:0] count;

    // Count request cycles; clear has priority so the next request starts at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Expiry is only meaningful while counting; the caller qualifies it with state.
    assign expire = (count == limit);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Data-memory bus master behind the MEM stage: turns a load/store into one
// req/ack transaction, stalls the pipeline meanwhile and returns the raw word.
//
// Bus handshake: bus_req is registered and, once raised, it and every other
// bus_* output hold still until the cycle in which bus_ack is seen high in
// REQ; that cycle completes the transfer (bus_err qualifies it as failed) and
// bus_req drops at the following edge. bus_ack outside REQ is ignored.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_BUS_TIMEOUT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ReadMem,
    input  logic                       WriteMem,
    input  logic [REG_DATA_WIDTH-1:0]  mem_addr,
    input  logic [BYTE_SLCT_WIDTH-1:0] byte_slct,
    input  logic [REG_DATA_WIDTH-1:0]  data_to_write_mem,
    output logic [REG_DATA_WIDTH-1:0]  raw_mem_data,
    output logic                       mem_stall,
    output logic                       mem_err,
    output logic                       bus_req,
    output logic                       bus_we,
    output logic [REG_DATA_WIDTH-1:0]  bus_addr,
    output logic [BYTE_SLCT_WIDTH-1:0] bus_be,
    output logic [REG_DATA_WIDTH-1:0]  bus_wdata,
    input  logic                       bus_ack,
    input  logic                       bus_err,
    input  logic [REG_DATA_WIDTH-1:0]  bus_rdata,
    output mbc_state_e                 state_dbg
);

    localparam logic [TMO_CNT_WIDTH-1:0] TIMEOUT_LIMIT = TMO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    mbc_state_e state;
    mbc_state_e state_next;
    logic       access;
    logic       tmo_expire;
    logic       req_exit;

    assign access    = (ReadMem | WriteMem) & (byte_slct != '0);
    assign req_exit  = (state == MBC_REQ) & (bus_ack | tmo_expire);
    assign state_dbg = state;

    // Held low through reset so a pending access cannot freeze the pipeline.
    assign mem_stall = rst & (((state == MBC_IDLE) & access) | (state == MBC_REQ));

    mbc_timeout_cnt u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    ((state != MBC_REQ) | req_exit),
        .en     (state == MBC_REQ),
        .limit  (TIMEOUT_LIMIT),
        .expire (tmo_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MBC_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> REQ on access, REQ -> DONE on ack or timeout, DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            MBC_IDLE: if (access) state_next = MBC_REQ;
            MBC_REQ:  if (bus_ack || tmo_expire) state_next = MBC_DONE;
            MBC_DONE: state_next = MBC_IDLE;
            default:  state_next = MBC_IDLE;
        endcase
    end

    // Bus outputs, read data and sticky error; latched request fields stay put until the next access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_be       <= '0;
            bus_wdata    <= '0;
            raw_mem_data <= '0;
            mem_err      <= 1'b0;
        end else begin
            case (state)
                MBC_IDLE: begin
                    if (access) begin
                        bus_req   <= 1'b1;
                        bus_we    <= WriteMem;
                        bus_addr  <= word_align(mem_addr);
                        bus_be    <= byte_slct;
                        bus_wdata <= data_to_write_mem;
                        // Simultaneous load and store is illegal; it proceeds as a store.
                        if (ReadMem && WriteMem) begin
                            mem_err <= 1'b1;
                        end
                    end
                end
                MBC_REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (bus_err) begin
                            mem_err <= 1'b1;
                            if (!bus_we) raw_mem_data <= '0;
                        end else if (!bus_we) begin
                            raw_mem_data <= bus_rdata;
                        end
                    end else if (tmo_expire) begin
                        bus_req <= 1'b0;
                        mem_err <= 1'b1;
                        if (!bus_we) raw_mem_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: per-scenario tasks with inline checks.
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        ReadMem;
  logic        WriteMem;
  logic [31:0] mem_addr;
  logic [3:0]  byte_slct;
  logic [31:0] data_to_write_mem;
  logic [31:0] raw_mem_data;
  logic        mem_stall;
  logic        mem_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;
  mbc_state_e  state_dbg;

  int passed = 0;
  int total  = 0;
  int stall_cycles;

  mem_bus_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .ReadMem(ReadMem), .WriteMem(WriteMem),
    .mem_addr(mem_addr), .byte_slct(byte_slct), .data_to_write_mem(data_to_write_mem),
    .raw_mem_data(raw_mem_data), .mem_stall(mem_stall), .mem_err(mem_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
    .state_dbg(state_dbg)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, then settle 1 ns past the edge before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ReadMem = 0; WriteMem = 0; mem_addr = '0; byte_slct = '0; data_to_write_mem = '0;
    bus_ack = 0; bus_err = 0; bus_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    tick(); tick();
    #2 rst = 1;
    tick();
    total++; if (state_dbg !== MBC_IDLE) $display("FAIL reset_state: got %0d want 0", state_dbg); else passed++;
    total++; if ({bus_req, bus_we, mem_err, mem_stall} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {bus_req, bus_we, mem_err, mem_stall}); else passed++;
    total++; if ({bus_addr, bus_be, bus_wdata, raw_mem_data} !== '0) $display("FAIL reset_data: got %h want 0", {bus_addr, bus_be, bus_wdata, raw_mem_data}); else passed++;
  endtask

  task automatic test_load_immediate_ack();
    stall_cycles = 0;
    ReadMem = 1; mem_addr = 32'h0000_1006; byte_slct = 4'b0011;
    #1 stall_cycles += int'(mem_stall);
    tick();  // REQ 1
    stall_cycles += int'(mem_stall);
    total++; if (bus_req !== 1'b1 || bus_we !== 1'b0) $display("FAIL load_req_we: got req=%b we=%b want 1 0", bus_req, bus_we); else passed++;
    total++; if (bus_addr !== 32'h0000_1004) $display("FAIL load_addr: got %h want 00001004", bus_addr); else passed++;
    total++; if (bus_be !== 4'b0011) $display("FAIL load_be: got %b want 0011", bus_be); else passed++;
    ReadMem = 0; mem_addr = 32'hFFFF_FFFF; byte_slct = 4'b1111;  // latched copies must be used
    bus_ack = 1; bus_rdata = 32'hDEAD_BEEF;
    #1 total++; if (bus_addr !== 32'h0000_1004) $display("FAIL load_addr_hold: got %h want 00001004", bus_addr); else passed++;
    tick();  // DONE
    bus_ack = 0; bus_rdata = '0; byte_slct = '0; mem_addr = '0;
    #1 stall_cycles += int'(mem_stall);
    total++; if (state_dbg !== MBC_DONE) $display("FAIL load_done_state: got %0d want 2", state_dbg); else passed++;
    total++; if (raw_mem_data !== 32'hDEAD_BEEF) $display("FAIL load_data: got %h want deadbeef", raw_mem_data); else passed++;
    total++; if (bus_req !== 1'b0) $display("FAIL load_req_drop: got %b want 0", bus_req); else passed++;
    total++; if (stall_cycles != 2) $display("FAIL load_stall_cycles: got %0d want 2", stall_cycles); else passed++;
    tick();  // IDLE
    total++; if (state_dbg !== MBC_IDLE) $display("FAIL load_back_idle: got %0d want 0", state_dbg); else passed++;
  endtask

  task automatic test_store_delayed_ack();
    stall_cycles = 0;
    WriteMem = 1; mem_addr = 32'h0000_2000; byte_slct = 4'b1111; data_to_write_mem = 32'h1234_5678;
    #1 stall_cycles += int'(mem_stall);
    tick();  // REQ 1
    stall_cycles += int'(mem_stall);
    total++; if (bus_we !== 1'b1 || bus_wdata !== 32'h1234_5678) $display("FAIL store_we_wdata: got we=%b wdata=%h want 1 12345678", bus_we, bus_wdata); else passed++;
    data_to_write_mem = 32'hAAAA_AAAA;
    tick();  // REQ 2
    stall_cycles += int'(mem_stall);
    total++; if (bus_req !== 1'b1 || bus_wdata !== 32'h1234_5678) $display("FAIL store_hold: got req=%b wdata=%h want 1 12345678", bus_req, bus_wdata); else passed++;
    tick();  // REQ 3, ack here
    stall_cycles += int'(mem_stall);
    bus_ack = 1;
    tick();  // DONE
    bus_ack = 0; WriteMem = 0; byte_slct = '0;
    #1 stall_cycles += int'(mem_stall);
    total++; if (stall_cycles != 4) $display("FAIL store_stall_cycles: got %0d want 4", stall_cycles); else passed++;
    total++; if (mem_err !== 1'b0 || state_dbg !== MBC_DONE) $display("FAIL store_done: got err=%b state=%0d want 0 2", mem_err, state_dbg); else passed++;
    total++; if (raw_mem_data !== 32'hDEAD_BEEF) $display("FAIL store_raw_kept: got %h want deadbeef", raw_mem_data); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    ReadMem = 1; mem_addr = 32'h0000_0010; byte_slct = 4'b1111;
    tick();  // REQ for first load
    bus_ack = 1; bus_rdata = 32'h1111_1111;
    tick();  // DONE; pipeline advances to the next load
    total++; if (raw_mem_data !== 32'h1111_1111) $display("FAIL b2b_first_data: got %h want 11111111", raw_mem_data); else passed++;
    bus_rdata = 32'h9999_9999;  // ack still high in DONE must be ignored
    mem_addr = 32'h0000_0020;
    tick();  // IDLE with second access pending
    bus_ack = 0;
    #1 total++; if (mem_stall !== 1'b1 || bus_req !== 1'b0 || raw_mem_data !== 32'h1111_1111) $display("FAIL b2b_idle: got stall=%b req=%b raw=%h want 1 0 11111111", mem_stall, bus_req, raw_mem_data); else passed++;
    tick();  // REQ for second load
    ReadMem = 0; byte_slct = '0;
    total++; if (bus_req !== 1'b1 || bus_addr !== 32'h0000_0020) $display("FAIL b2b_second_req: got req=%b addr=%h want 1 00000020", bus_req, bus_addr); else passed++;
    bus_ack = 1; bus_rdata = 32'h2222_2222;
    tick();  // DONE
    bus_ack = 0;
    total++; if (raw_mem_data !== 32'h2222_2222) $display("FAIL b2b_second_data: got %h want 22222222", raw_mem_data); else passed++;
    tick();
  endtask

  task automatic test_non_mem();
    ReadMem = 1; byte_slct = 4'b0000; mem_addr = 32'h0000_0040;
    #1 total++; if (mem_stall !== 1'b0) $display("FAIL nonmem_stall: got %b want 0", mem_stall); else passed++;
    tick(); tick();
    total++; if (bus_req !== 1'b0 || state_dbg !== MBC_IDLE) $display("FAIL nonmem_idle: got req=%b state=%0d want 0 0", bus_req, state_dbg); else passed++;
    ReadMem = 0;
  endtask

  task automatic test_timeout();
    ReadMem = 1; mem_addr = 32'h0000_3000; byte_slct = 4'b1111;
    tick();  // REQ cycle 1
    ReadMem = 0; byte_slct = '0;
    for (int i = 2; i <= 16; i++) begin
      tick();
      total++; if (bus_req !== 1'b1 || mem_stall !== 1'b1) $display("FAIL timeout_wait_%0d: got req=%b stall=%b want 1 1", i, bus_req, mem_stall); else passed++;
    end
    tick();  // DONE after 16 REQ cycles
    total++; if (bus_req !== 1'b0 || state_dbg !== MBC_DONE) $display("FAIL timeout_abort: got req=%b state=%0d want 0 2", bus_req, state_dbg); else passed++;
    total++; if (mem_err !== 1'b1 || raw_mem_data !== 32'h0 || mem_stall !== 1'b0) $display("FAIL timeout_result: got err=%b raw=%h stall=%b want 1 0 0", mem_err, raw_mem_data, mem_stall); else passed++;
    tick();
    total++; if (mem_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", mem_err); else passed++;
  endtask

  task automatic test_reset_mid_op();
    ReadMem = 1; mem_addr = 32'h0000_5004; byte_slct = 4'b1111;
    tick();  // REQ
    total++; if (bus_req !== 1'b1) $display("FAIL rstmid_req: got %b want 1", bus_req); else passed++;
    rst = 0;
    #1 total++; if (bus_req !== 1'b0 || state_dbg !== MBC_IDLE || mem_stall !== 1'b0 || mem_err !== 1'b0) $display("FAIL rstmid_async: got req=%b state=%0d stall=%b err=%b want 0 0 0 0", bus_req, state_dbg, mem_stall, mem_err); else passed++;
    total++; if ({bus_addr, bus_be, bus_wdata, raw_mem_data, bus_we} !== '0) $display("FAIL rstmid_data: got %h want 0", {bus_addr, bus_be, bus_wdata, raw_mem_data, bus_we}); else passed++;
    idle_inputs();
    tick();
    #2 rst = 1;
    tick();
    total++; if (bus_req !== 1'b0 || state_dbg !== MBC_IDLE) $display("FAIL rstmid_no_retry: got req=%b state=%0d want 0 0", bus_req, state_dbg); else passed++;
  endtask

  task automatic test_bus_error();
    WriteMem = 1; mem_addr = 32'h0000_4000; byte_slct = 4'b1111; data_to_write_mem = 32'hCAFE_F00D;
    tick();  // REQ
    WriteMem = 0; byte_slct = '0;
    bus_ack = 1; bus_err = 1;
    tick();  // DONE
    bus_ack = 0; bus_err = 0;
    total++; if (mem_err !== 1'b1 || state_dbg !== MBC_DONE || bus_req !== 1'b0) $display("FAIL buserr_done: got err=%b state=%0d req=%b want 1 2 0", mem_err, state_dbg, bus_req); else passed++;
    tick();  // IDLE
    ReadMem = 1; mem_addr = 32'h0000_400A; byte_slct = 4'b1100;
    tick();  // REQ
    ReadMem = 0; byte_slct = '0;
    total++; if (bus_addr !== 32'h0000_4008 || bus_be !== 4'b1100 || bus_we !== 1'b0) $display("FAIL buserr_next_req: got addr=%h be=%b we=%b want 00004008 1100 0", bus_addr, bus_be, bus_we); else passed++;
    bus_ack = 1; bus_rdata = 32'h55AA_0000;
    tick();  // DONE
    bus_ack = 0;
    total++; if (raw_mem_data !== 32'h55AA_0000 || mem_err !== 1'b1) $display("FAIL buserr_next_load: got raw=%h err=%b want 55aa0000 1", raw_mem_data, mem_err); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_immediate_ack();
    test_store_delayed_ack();
    test_back_to_back();
    test_non_mem();
    test_timeout();
    test_reset_mid_op();
    test_bus_error();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
